// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine sequencer: state encoding and
// the clamp used when latching the requested number of wash passes.
package wm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SOAK  = 3'd1,
      ST_WASH  = 3'd2,
      ST_RINSE = 3'd3,
      ST_SPIN  = 3'd4,
      ST_DRAIN = 3'd5
   } wm_state_e;

   // A request of 0 means one pass; anything above the maximum is capped.
   function automatic int unsigned clamp_passes(input int unsigned req,
                                                input int unsigned max_p);
      if (req == 0) begin
         return 1;
      end else if (req > max_p) begin
         return max_p;
      end else begin
         return req;
      end
   endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Down-counting phase timer. A load sets the count; while enabled it counts
// down to zero and raises done on the enabled cycle in which it reads zero.
module wm_phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             done
);

   logic [CNT_W-1:0] timer_q;
   logic [CNT_W-1:0] timer_d;

   // Load has priority over counting; a disabled timer holds its value.
   always_comb begin
      timer_d = timer_q;
      if (load) begin
         timer_d = load_val;
      end else if (en && (timer_q != '0)) begin
         timer_d = timer_q - CNT_W'(1);
      end
   end

   // Timer register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign done = en && (timer_q == '0);

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine sequencer: IDLE -> SOAK -> (WASH -> RINSE) x N -> SPIN -> IDLE.
// Optional feature macro WM_DRAIN_EN inserts a DRAIN phase before SPIN.
module wash_cycle_ctrl
   import wm_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int SOAK_CYC   = 10,
   parameter int WASH_CYC   = 30,
   parameter int RINSE_CYC  = 10,
   parameter int SPIN_CYC   = 10,
   parameter int DRAIN_CYC  = 4,
   parameter int MAX_PASSES = 3,
   localparam int PASS_W    = $clog2(MAX_PASSES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              coin_insert,
   input  logic [PASS_W-1:0] passes_req,
   input  logic              lid,
   input  logic              abort,
   output logic [2:0]        state_o,
   output logic              busy,
   output logic [PASS_W-1:0] pass_cnt,
   output logic              lid_pause,
   output logic              laundry_done,
   output logic              aborted
);

   // State entered after the last rinse or after an abort.
`ifdef WM_DRAIN_EN
   localparam wm_state_e POST_WASH_ST = ST_DRAIN;
`else
   localparam wm_state_e POST_WASH_ST = ST_SPIN;
`endif

   wm_state_e         state_q, state_d;
   logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [PASS_W-1:0] passes_tgt_q, passes_tgt_d;
   logic              aborted_q, aborted_d;
   logic              busy_q, busy_d;
   logic              laundry_done_q, laundry_done_d;

   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_load_val;
   logic              tmr_en;
   logic              tmr_done;
   logic [PASS_W:0]   pass_next_w;

   assign pass_next_w = (PASS_W+1)'(pass_cnt_q) + (PASS_W+1)'(1);

   // Next-state, pass bookkeeping and done-pulse logic; abort beats timer done.
   always_comb begin
      state_d        = state_q;
      pass_cnt_d     = pass_cnt_q;
      passes_tgt_d   = passes_tgt_q;
      aborted_d      = aborted_q;
      laundry_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (coin_insert) begin
               state_d      = ST_SOAK;
               passes_tgt_d = PASS_W'(clamp_passes(int'(passes_req), MAX_PASSES));
               pass_cnt_d   = '0;
               aborted_d    = 1'b0;
            end
         end
         ST_SOAK: begin
            if (abort) begin
               state_d   = POST_WASH_ST;
               aborted_d = 1'b1;
            end else if (tmr_done) begin
               state_d = ST_WASH;
            end
         end
         ST_WASH: begin
            if (abort) begin
               state_d   = POST_WASH_ST;
               aborted_d = 1'b1;
            end else if (tmr_done) begin
               state_d = ST_RINSE;
            end
         end
         ST_RINSE: begin
            if (abort) begin
               state_d   = POST_WASH_ST;
               aborted_d = 1'b1;
            end else if (tmr_done) begin
               if (pass_cnt_q < PASS_W'(MAX_PASSES)) begin
                  pass_cnt_d = pass_cnt_q + PASS_W'(1);
               end
               if (pass_next_w < (PASS_W+1)'(passes_tgt_q)) begin
                  state_d = ST_WASH;
               end else begin
                  state_d = POST_WASH_ST;
               end
            end
         end
`ifdef WM_DRAIN_EN
         ST_DRAIN: begin
            if (tmr_done) begin
               state_d = ST_SPIN;
            end
         end
`endif
         ST_SPIN: begin
            if (tmr_done) begin
               state_d        = ST_IDLE;
               laundry_done_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Timer reload on every phase change, with the duration of the phase entered.
   always_comb begin
      tmr_load     = (state_d != state_q);
      tmr_load_val = '0;
      case (state_d)
         ST_SOAK:  tmr_load_val = CNT_W'(SOAK_CYC - 1);
         ST_WASH:  tmr_load_val = CNT_W'(WASH_CYC - 1);
         ST_RINSE: tmr_load_val = CNT_W'(RINSE_CYC - 1);
         ST_SPIN:  tmr_load_val = CNT_W'(SPIN_CYC - 1);
         ST_DRAIN: tmr_load_val = CNT_W'(DRAIN_CYC - 1);
         default:  tmr_load_val = '0;
      endcase
   end

   assign busy_d = (state_d != ST_IDLE);
   assign tmr_en = busy_q && !lid;

   wm_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .en       (tmr_en),
      .done     (tmr_done)
   );

   // Controller state and registered outputs, asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         pass_cnt_q     <= '0;
         passes_tgt_q   <= PASS_W'(1);
         aborted_q      <= 1'b0;
         busy_q         <= 1'b0;
         laundry_done_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pass_cnt_q     <= pass_cnt_d;
         passes_tgt_q   <= passes_tgt_d;
         aborted_q      <= aborted_d;
         busy_q         <= busy_d;
         laundry_done_q <= laundry_done_d;
      end
   end

   assign state_o      = state_q;
   assign busy         = busy_q;
   assign pass_cnt     = pass_cnt_q;
   assign aborted      = aborted_q;
   assign laundry_done = laundry_done_q;
   assign lid_pause    = lid && busy_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Self-checking bench for wash_cycle_ctrl (default parameters).
// Honours WM_DRAIN_EN when the design is built with it.
module tb_wash_cycle_ctrl;

   localparam int S_IDLE  = 0;
   localparam int S_SOAK  = 1;
   localparam int S_WASH  = 2;
   localparam int S_RINSE = 3;
   localparam int S_SPIN  = 4;
   localparam int S_DRAIN = 5;
`ifdef WM_DRAIN_EN
   localparam int D      = 4;
   localparam int S_POST = S_DRAIN;
`else
   localparam int D      = 0;
   localparam int S_POST = S_SPIN;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       coin_insert;
   logic [1:0] passes_req;
   logic       lid;
   logic       abort;
   logic [2:0] state_o;
   logic       busy;
   logic [1:0] pass_cnt;
   logic       lid_pause;
   logic       laundry_done;
   logic       aborted;

   int checks = 0;
   int errors = 0;

   wash_cycle_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .coin_insert  (coin_insert),
      .passes_req   (passes_req),
      .lid          (lid),
      .abort        (abort),
      .state_o      (state_o),
      .busy         (busy),
      .pass_cnt     (pass_cnt),
      .lid_pause    (lid_pause),
      .laundry_done (laundry_done),
      .aborted      (aborted)
   );

   always #5 clk = ~clk;

   typedef struct {
      int req;
      int coin2_at;
      int exp_total;
      int exp_wash;
      int exp_rinse;
      int exp_pass;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end else begin
         $display("ok   %s = %0d", nm, act);
      end
   endtask

   // Accept a coin, then run until laundry_done while tallying phase lengths.
   task automatic run_to_done(input int req, input int coin2_at,
                              input int lid_from, input int lid_len,
                              output int total, output int soak, output int wash,
                              output int rinse, output int drain, output int spin,
                              output int lidp);
      int cyc;
      soak = 0; wash = 0; rinse = 0; drain = 0; spin = 0; lidp = 0;
      passes_req  = 2'(req);
      coin_insert = 1'b1;
      tick();
      coin_insert = 1'b0;
      cyc = 1;
      while (cyc < 2000) begin
         if (laundry_done) break;
         case (int'(state_o))
            S_SOAK:  soak++;
            S_WASH:  wash++;
            S_RINSE: rinse++;
            S_DRAIN: drain++;
            S_SPIN:  spin++;
            default: ;
         endcase
         lid = (int'(state_o) == S_WASH) && (lid_len > 0) &&
               (wash > lid_from) && (wash <= lid_from + lid_len);
         coin_insert = (cyc == coin2_at);
         if (coin_insert) passes_req = 2'd1;
         #1;
         if (lid_pause) lidp++;
         tick();
         cyc++;
      end
      lid = 1'b0;
      coin_insert = 1'b0;
      total = cyc;
   endtask

   initial begin
      int total, soak, wash, rinse, drain, spin, lidp, rc, c, n_done, n_busy;

      vecs[0] = '{req: 1, coin2_at: 0,  exp_total: 61  + D, exp_wash: 30, exp_rinse: 10, exp_pass: 1};
      vecs[1] = '{req: 3, coin2_at: 50, exp_total: 141 + D, exp_wash: 90, exp_rinse: 30, exp_pass: 3};
      vecs[2] = '{req: 0, coin2_at: 0,  exp_total: 61  + D, exp_wash: 30, exp_rinse: 10, exp_pass: 1};
      vecs[3] = '{req: 2, coin2_at: 0,  exp_total: 101 + D, exp_wash: 60, exp_rinse: 20, exp_pass: 2};

      rst = 1'b0; coin_insert = 1'b0; passes_req = 2'd0; lid = 1'b0; abort = 1'b0;
      tick(); tick();
      chk("rst_state", int'(state_o), S_IDLE);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pass_cnt", int'(pass_cnt), 0);
      chk("rst_lid_pause", int'(lid_pause), 0);
      chk("rst_done", int'(laundry_done), 0);
      chk("rst_aborted", int'(aborted), 0);
      rst = 1'b1;
      tick();

      // Lid and abort are both ignored in IDLE.
      lid = 1'b1; abort = 1'b1;
      #1;
      chk("idle_lid_pause", int'(lid_pause), 0);
      tick(); tick();
      chk("idle_abort_state", int'(state_o), S_IDLE);
      chk("idle_abort_flag", int'(aborted), 0);
      lid = 1'b0; abort = 1'b0;
      tick();

      for (int i = 0; i < 4; i++) begin
         run_to_done(vecs[i].req, vecs[i].coin2_at, 0, 0,
                     total, soak, wash, rinse, drain, spin, lidp);
         $display("run req=%0d total=%0d pass_cnt=%0d", vecs[i].req, total, pass_cnt);
         chk($sformatf("v%0d_total", i), total, vecs[i].exp_total);
         chk($sformatf("v%0d_soak", i), soak, 10);
         chk($sformatf("v%0d_wash", i), wash, vecs[i].exp_wash);
         chk($sformatf("v%0d_rinse", i), rinse, vecs[i].exp_rinse);
         chk($sformatf("v%0d_drain", i), drain, D);
         chk($sformatf("v%0d_spin", i), spin, 10);
         chk($sformatf("v%0d_pass_cnt", i), int'(pass_cnt), vecs[i].exp_pass);
         chk($sformatf("v%0d_busy_end", i), int'(busy), 0);
         chk($sformatf("v%0d_aborted", i), int'(aborted), 0);
         tick();
         chk($sformatf("v%0d_done_pulse_1cyc", i), int'(laundry_done), 0);
      end

      // Lid open for 5 cycles mid-WASH stretches WASH to 35 cycles.
      run_to_done(1, 0, 15, 5, total, soak, wash, rinse, drain, spin, lidp);
      $display("lid run total=%0d wash=%0d", total, wash);
      chk("lid_wash_len", wash, 35);
      chk("lid_pause_cycles", lidp, 5);
      chk("lid_total", total, 66 + D);
      tick();

      // Abort on the cycle RINSE would finish pass 1 of 2.
      passes_req = 2'd2; coin_insert = 1'b1;
      tick();
      coin_insert = 1'b0;
      rc = 0;
      for (int k = 0; k < 200; k++) begin
         if (int'(state_o) == S_RINSE) rc++;
         if (rc == 10) break;
         tick();
      end
      chk("abort_reached_rinse_end", rc, 10);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_state", int'(state_o), S_POST);
      chk("abort_pass_cnt", int'(pass_cnt), 0);
      chk("abort_flag", int'(aborted), 1);
      c = 1;
      while (!laundry_done && c < 100) begin
         tick();
         c++;
      end
      chk("abort_done_latency", c, D + 11);
      chk("abort_flag_at_done", int'(aborted), 1);
      tick();
      passes_req = 2'd1; coin_insert = 1'b1;
      tick();
      coin_insert = 1'b0;
      chk("coin_clears_aborted", int'(aborted), 0);
      chk("coin_state_soak", int'(state_o), S_SOAK);
      chk("coin_busy", int'(busy), 1);

      // Reset asserted mid-SPIN returns to IDLE at once and suppresses the done pulse.
      rc = 0;
      for (int k = 0; k < 200; k++) begin
         if (int'(state_o) == S_SPIN) rc++;
         if (rc == 3) break;
         tick();
      end
      chk("reset_reached_spin", rc, 3);
      rst = 1'b0; lid = 1'b1;
      #1;
      chk("midrst_state", int'(state_o), S_IDLE);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_pass_cnt", int'(pass_cnt), 0);
      chk("midrst_lid_pause", int'(lid_pause), 0);
      chk("midrst_done", int'(laundry_done), 0);
      tick(); tick();
      lid = 1'b0; rst = 1'b1;
      n_done = 0; n_busy = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (laundry_done) n_done++;
         if (busy) n_busy++;
      end
      chk("post_rst_done_pulses", n_done, 0);
      chk("post_rst_busy_cycles", n_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
